// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset/halt defaults
// and the word-alignment helper used on redirect targets.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP       = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect request from a
// later stage and the fetch->decode handshake. The master side is the fetch
// stage itself; the slave side is its environment (memory, branch unit, decode).
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        br_valid;
    logic [31:0] br_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  br_valid,
        input  br_target,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output br_valid,
        output br_target,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: redirect beats increment, increment beats hold.
// The increment wraps naturally modulo 2^32.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        incr_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Select the next PC: redirect, sequential step, or hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_word(target_i);
        end else if (incr_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC state register with synchronous reset to RESET_PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE/RUN/HALT control, one-instruction-per-cycle
// fetch into a single decode-facing register, redirect/flush and halt detect.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus,
    output logic          halted,
    output logic          misalign
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [31:0] pc;
    logic        redirect;
    logic        fire;
    logic        is_halt;
    logic        load;

    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_plus4_q;
    logic        misalign_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .redirect_i (redirect),
        .target_i   (bus.br_target),
        .incr_i     (load),
        .pc_o       (pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect always returns to RUN; a fetched halt word parks in HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect) begin
                    state_d = ST_RUN;
                end else if (fire && is_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and fetch qualifiers; redirects are ignored while IDLE.
    always_comb begin
        halted   = (state_q == ST_HALT);
        redirect = bus.br_valid && (state_q != ST_IDLE);
        fire     = (state_q == ST_RUN) && !bus.br_valid && (!id_valid_q || bus.id_ready);
        is_halt  = (bus.imem_rd == HALT_WORD);
        load     = fire && !is_halt;
    end

    // Decode-facing register: flush on redirect, load on fire, drain in HALT, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'h0;
            id_pc_q       <= 32'h0;
            id_pc_plus4_q <= PC_STEP;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= redirect && (|bus.br_target[1:0]);
            if (redirect) begin
                id_valid_q <= 1'b0;
            end else if (fire) begin
                if (is_halt) begin
                    id_valid_q <= 1'b0;
                end else begin
                    id_valid_q    <= 1'b1;
                    id_instr_q    <= bus.imem_rd;
                    id_pc_q       <= pc;
                    id_pc_plus4_q <= pc + PC_STEP;
                end
            end else if ((state_q == ST_HALT) && bus.id_ready) begin
                id_valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign misalign        = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small combinational instruction memory,
// linear stimulus, hand-computed expectations after every clock edge.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    logic halted;
    logic misalign;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.master),
        .halted   (halted),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory, 64 words, address bits [7:2].
    always_comb bus.imem_rd = mem[bus.imem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, settle, and confirm the halt word never reaches decode.
    task automatic step();
        @(posedge clk);
        #1;
        chk("no_halt_to_decode", {31'b0, bus.id_valid && (bus.id_instr == HALT)}, 32'h0);
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, {31'b0, bus.id_valid}, 32'h1);
        chk({tag, "_pc"}, bus.id_pc, pc);
        chk({tag, "_instr"}, bus.id_instr, instr);
        chk({tag, "_plus4"}, bus.id_pc_plus4, pc + 32'd4);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'b0, bus.id_valid}, 32'h0);
        chk({tag, "_instr"}, bus.id_instr, 32'h0);
        chk({tag, "_pc"}, bus.id_pc, 32'h0);
        chk({tag, "_plus4"}, bus.id_pc_plus4, 32'h4);
        chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
        chk({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
        chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[2]  = 32'h33;
        mem[3]  = HALT;
        mem[8]  = 32'h88;
        mem[16] = 32'h40;
        mem[63] = 32'hAA;

        reset         = 1'b1;
        bus.br_valid  = 1'b0;
        bus.br_target = 32'h0;
        bus.id_ready  = 1'b1;
        step();
        step();
        chk_reset_vals("reset");

        // IDLE cycle: no fetch yet.
        reset = 1'b0;
        step();
        chk("idle_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("idle_addr", bus.imem_addr, 32'h0);

        // Back-to-back fetch.
        step();
        chk_id("f0", 32'h0, 32'h11);
        chk("f0_addr", bus.imem_addr, 32'h4);
        step();
        chk_id("f1", 32'h4, 32'h22);
        chk("f1_addr", bus.imem_addr, 32'h8);

        // Three-cycle stall holding 0x22.
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_id("stall", 32'h4, 32'h22);
            chk("stall_addr", bus.imem_addr, 32'h8);
        end
        bus.id_ready = 1'b1;
        step();
        chk_id("release", 32'h8, 32'h33);
        chk("release_addr", bus.imem_addr, 32'hC);

        // Halt word at 0xC.
        step();
        chk("halt_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        chk("halt_addr", bus.imem_addr, 32'hC);
        step();
        step();
        chk("halt_hold_flag", {31'b0, halted}, 32'h1);
        chk("halt_hold_addr", bus.imem_addr, 32'hC);
        chk("halt_hold_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("halt_hold_pc", bus.id_pc, 32'h8);

        // Redirect out of HALT to 0.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h0;
        step();
        bus.br_valid = 1'b0;
        chk("unhalt_flag", {31'b0, halted}, 32'h0);
        chk("unhalt_addr", bus.imem_addr, 32'h0);
        chk("unhalt_valid", {31'b0, bus.id_valid}, 32'h0);
        step();
        chk_id("resume0", 32'h0, 32'h11);
        step();
        chk_id("resume1", 32'h4, 32'h22);

        // Redirect to 0x20 while stalled.
        bus.id_ready = 1'b0;
        step();
        chk_id("stall2", 32'h4, 32'h22);
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h20;
        step();
        bus.br_valid = 1'b0;
        bus.id_ready = 1'b1;
        chk("br20_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("br20_addr", bus.imem_addr, 32'h20);
        chk("br20_misalign", {31'b0, misalign}, 32'h0);
        step();
        chk_id("br20_fetch", 32'h20, 32'h88);

        // Misaligned redirect to 0x23.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h23;
        step();
        bus.br_valid = 1'b0;
        chk("br23_addr", bus.imem_addr, 32'h20);
        chk("br23_misalign", {31'b0, misalign}, 32'h1);
        chk("br23_valid", {31'b0, bus.id_valid}, 32'h0);
        step();
        chk("br23_misalign_drop", {31'b0, misalign}, 32'h0);
        chk_id("br23_fetch", 32'h20, 32'h88);

        // Wrap from 0xFFFF_FFFC back to 0.
        bus.br_valid  = 1'b1;
        bus.br_target = 32'hFFFF_FFFC;
        step();
        bus.br_valid = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_misalign", {31'b0, misalign}, 32'h0);
        step();
        chk_id("wrap_top", 32'hFFFF_FFFC, 32'hAA);
        chk("wrap_plus4", bus.id_pc_plus4, 32'h0);
        chk("wrap_addr0", bus.imem_addr, 32'h0);
        step();
        chk_id("wrap_zero", 32'h0, 32'h11);

        // Run into HALT again, then reset with a redirect pending.
        step();
        step();
        step();
        chk("halt2_flag", {31'b0, halted}, 32'h1);
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h40;
        reset         = 1'b1;
        step();
        chk_reset_vals("reset_in_halt");

        // Redirect is ignored in IDLE.
        reset = 1'b0;
        step();
        chk("idle_br_addr", bus.imem_addr, 32'h0);
        chk("idle_br_misalign", {31'b0, misalign}, 32'h0);
        bus.br_valid = 1'b0;
        step();
        chk_id("post_idle", 32'h0, 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, is the instruction encoding that stops fetch.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  byte address to instruction memory; equals the PC register, combinational.
REQ-006 imem_rd  input  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-007 br_valid  input  1  redirect request from a later stage, valid for one cycle.
REQ-008 br_target  input  32  redirect byte address, sampled when br_valid=1.
REQ-009 id_ready  input  1  decode stage accepts id_instr this cycle.
REQ-010 id_valid  output  1  id_instr/id_pc/id_pc_plus4 hold a valid fetched instruction.
REQ-011 id_instr  output  32  registered instruction word.
REQ-012 id_pc  output  32  byte address of id_instr.
REQ-013 id_pc_plus4  output  32  id_pc + 4, modulo 2^32.
REQ-014 halted  output  1  high while the FSM is in HALT.
REQ-015 misalign  output  1  one-cycle pulse: the last accepted br_target had bits [1:0] != 0.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALT; IDLE -> RUN unconditionally after one cycle, with no fetch in IDLE.
REQ-017 fire = state==RUN && !br_valid && (!id_valid || id_ready).
REQ-018 On fire with imem_rd != HALT_WORD: id_instr<=imem_rd, id_pc<=pc, id_valid<=1, pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0).
REQ-019 On fire with imem_rd == HALT_WORD: id_valid<=0, pc holds, state -> HALT; the halt word is never presented to decode.
REQ-020 In RUN with id_valid=1 and id_ready=0 and br_valid=0 (stall): pc, id_* and state SHALL hold.
REQ-021 In RUN or HALT, br_valid=1 SHALL win over fire, stall and halt: pc<=br_target with bits [1:0] forced to 0, id_valid<=0 (flush), state -> RUN, misalign<=|br_target[1:0] for one cycle.
REQ-022 In IDLE, br_valid SHALL be ignored.
REQ-023 In HALT without br_valid: pc holds, no fetch; id_valid clears when id_ready=1, otherwise holds.
REQ-024 id_instr, id_pc, id_pc_plus4 hold their last values whenever id_valid=0 or stalled.
REQ-025 Fetch throughput is one instruction per cycle when id_ready stays 1; latency imem_addr -> id_instr is one cycle.

Reset
REQ-026 reset=1 SHALL set pc=RESET_PC, state=IDLE, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4, halted=0, misalign=0 at the next edge.
REQ-027 reset SHALL override every other input, including br_valid and mid-stall or HALT state.

Structure
REQ-028 FSM state encoding, RESET_PC default and HALT_WORD default SHALL live in a shared package cpu_pkg.
REQ-029 Optional single sub-module pc_reg (PC register with redirect/increment/hold mux); otherwise flat.

Verification
REQ-030 Reset, RESET_PC=0, imem holds 0x11,0x22,0x33 at words 0..2, id_ready=1 -> id_valid rises on cycle 2; id_pc 0,4,8 with id_instr 0x11,0x22,0x33 on consecutive cycles.
REQ-031 id_ready=0 for 3 cycles with id_instr=0x22 -> imem_addr stays 8, id_* unchanged; release -> 0x33 next cycle, nothing lost or duplicated.
REQ-032 br_valid=1, br_target=0x20 during a stall -> next cycle id_valid=0, imem_addr=0x20, misalign=0; following cycle id_pc=0x20.
REQ-033 br_target=0x23 -> imem_addr=0x20, misalign=1 for exactly one cycle.
REQ-034 HALT_WORD at word 3 -> halted=1, imem_addr stays 0xC, id_valid never shows 0xFFFF_FFFF; then br_valid to 0x0 -> RUN, fetch resumes at 0.
REQ-035 PC preset near 32'hFFFF_FFFC via redirect -> next id_pc=0 after wrap; reset asserted in HALT -> all outputs at REQ-026 values.
